// File: rtl/button_press_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : button_press_decoder
//  Purpose  : Receive-side conditioner for one active-low push button.
//             Synchronises and debounces the raw pin, classifies each press
//             as short or long, and emits auto-repeat pulses while the
//             button stays held after a long press. Every event output is
//             a clean single-cycle pulse.
//  Ports    : clk50m       in  system clock, all logic on the rising edge
//             rst_n        in  asynchronous active-low reset
//             button_n     in  raw button pin, 0 = pressed, asynchronous
//             pressed      out debounced level, 1 = pressed
//             press_short  out 1-cycle pulse, released before long threshold
//             press_long   out 1-cycle pulse, hold reached long threshold
//             press_repeat out 1-cycle pulse every repeat period while held
//  Revision : 1.0 - initial release
// ============================================================================
module button_press_decoder #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic button_n,
    output logic pressed,
    output logic press_short,
    output logic press_long,
    output logic press_repeat
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser. Both flops reset to the released level so a
    // held button after reset is seen as a fresh edge and re-debounced.
    // ------------------------------------------------------------------
    logic sync_meta;
    logic sync_n;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_n    <= 1'b1;
        end else begin
            sync_meta <= button_n;
            sync_n    <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the synced level must differ from the accepted level for
    // DEBOUNCE_CYCLES consecutive cycles before it is taken. Any return to
    // the accepted level restarts the count.
    // ------------------------------------------------------------------
    logic            stable;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            db_cnt <= '0;
        end else if (sync_n == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= sync_n;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Inverter straight off the stable flop: the level changes on the same
    // edge the new value is accepted (2 sync + DEBOUNCE_CYCLES latency).
    assign pressed = ~stable;

    // ------------------------------------------------------------------
    // Press classifier FSM
    // ------------------------------------------------------------------
    state_t              state;
    state_t              next_state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   next_hold;
    logic [REP_W-1:0]    rep_cnt;
    logic [REP_W-1:0]    next_rep;
    logic                next_short;
    logic                next_long;
    logic                next_repeat;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            press_short  <= 1'b0;
            press_long   <= 1'b0;
            press_repeat <= 1'b0;
        end else begin
            state        <= next_state;
            hold_cnt     <= next_hold;
            rep_cnt      <= next_rep;
            press_short  <= next_short;
            press_long   <= next_long;
            press_repeat <= next_repeat;
        end
    end

    always_comb begin
        next_state  = state;
        next_hold   = hold_cnt;
        next_rep    = rep_cnt;
        next_short  = 1'b0;
        next_long   = 1'b0;
        next_repeat = 1'b0;

        case (state)
            S_IDLE: begin
                if (pressed) begin
                    next_state = S_PRESSED;
                    next_hold  = HOLD_W'(1);
                end
            end

            // Release is tested first so a release landing on the long
            // threshold cycle still reports a short press.
            S_PRESSED: begin
                if (!pressed) begin
                    next_short = 1'b1;
                    next_state = S_IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    next_long  = 1'b1;
                    next_state = S_HELD;
                    next_rep   = '0;
                end else begin
                    next_hold = hold_cnt + 1'b1;
                end
            end

            // hold_cnt is frozen here; rep_cnt clears at its terminal
            // count, so neither counter can wrap.
            S_HELD: begin
                if (!pressed) begin
                    next_state = S_IDLE;
                end else if (rep_cnt == REP_LAST) begin
                    next_repeat = 1'b1;
                    next_rep    = '0;
                end else begin
                    next_rep = rep_cnt + 1'b1;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
